seven_seg_capture: RTL and testbench

//   Receive-side monitor for the multiplexed two-digit seven-segment display bus.

---
 rtl/seven_seg_capture_if.sv | 23 ++
 rtl/seven_seg_capture.sv | 159 +++++++++++++++
 tb/tb_seven_seg_capture.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_capture_if.sv
// Display-bus bundle between a seven-segment driver (master) and the capture monitor (slave).
// Segment and digit-enable lines are active-low.
interface seven_seg_capture_if;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [1:0] valid;
    logic       frame_pulse;
    logic       err_pulse;
    logic [6:0] err_seg;
    logic       stale;

    modport master (
        output seg, an,
        input  digit0, digit1, valid, frame_pulse, err_pulse, err_seg, stale
    );

    modport slave (
        input  seg, an,
        output digit0, digit1, valid, frame_pulse, err_pulse, err_seg, stale
    );
endinterface

// File: rtl/seven_seg_capture.sv
// Receive-side monitor for a two-digit multiplexed seven-segment bus: debounces the
// {an,seg} lines, decodes stable patterns to hex digits and flags errors and staleness.
module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input logic                clk,
    input logic                reset,
    seven_seg_capture_if.slave bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [8:0]    IDLE_SMP = {2'b11, 7'h7F};

    // {found, value}: found=0 for blank and for any code outside the hex table
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h01:   r = {1'b1, 4'h0};
            7'h4F:   r = {1'b1, 4'h1};
            7'h12:   r = {1'b1, 4'h2};
            7'h06:   r = {1'b1, 4'h3};
            7'h4C:   r = {1'b1, 4'h4};
            7'h24:   r = {1'b1, 4'h5};
            7'h20:   r = {1'b1, 4'h6};
            7'h0F:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h04:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h60:   r = {1'b1, 4'hB};
            7'h72:   r = {1'b1, 4'hC};
            7'h42:   r = {1'b1, 4'hD};
            7'h10:   r = {1'b1, 4'hE};
            7'h38:   r = {1'b1, 4'hF};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    logic [8:0]    smp_q,     smp_d;
    logic [SW-1:0] cnt_q,     cnt_d;
    logic [3:0]    digit0_q,  digit0_d;
    logic [3:0]    digit1_q,  digit1_d;
    logic [1:0]    valid_q,   valid_d;
    logic [1:0]    flag_q,    flag_d;
    logic          frame_q,   frame_d;
    logic          err_q,     err_d;
    logic [6:0]    err_seg_q, err_seg_d;
    logic          stale_q,   stale_d;
    logic [TW-1:0] tmo_q,     tmo_d;

    logic       same;
    logic       stable_ev;
    logic       one_hot;
    logic       blank;
    logic [4:0] dec;
    logic       capture;
    logic [1:0] flag_new;

    always_comb begin
        smp_d     = {bus.an, bus.seg};
        cnt_d     = '0;
        digit0_d  = digit0_q;
        digit1_d  = digit1_q;
        valid_d   = valid_q;
        flag_d    = flag_q;
        frame_d   = 1'b0;
        err_d     = 1'b0;
        err_seg_d = err_seg_q;
        stale_d   = stale_q;
        tmo_d     = tmo_q;
        flag_new  = flag_q;

        same = (smp_d == smp_q);
        if (same) begin
            cnt_d = (cnt_q == STAB_MAX) ? cnt_q : cnt_q + 1'b1;
        end

        // The event fires on the edge that takes the run count to its limit, so the
        // pattern being captured is the one already held in smp_q.
        stable_ev = same && (cnt_q == STAB_MAX - 1'b1);
        one_hot   = (smp_q[8:7] == 2'b10) || (smp_q[8:7] == 2'b01);
        blank     = (smp_q[6:0] == 7'h7F);
        dec       = seg_decode(smp_q[6:0]);
        capture   = stable_ev && one_hot && !blank && dec[4];

        if (capture) begin
            if (smp_q[7] == 1'b0) begin
                digit0_d    = dec[3:0];
                valid_d[0]  = 1'b1;
                flag_new[0] = 1'b1;
            end else begin
                digit1_d    = dec[3:0];
                valid_d[1]  = 1'b1;
                flag_new[1] = 1'b1;
            end
            if (&flag_new) begin
                frame_d = 1'b1;
                flag_d  = 2'b00;
            end else begin
                flag_d  = flag_new;
            end
            tmo_d   = '0;
            stale_d = 1'b0;
        end else begin
            if (stable_ev && one_hot && !blank) begin
                err_d     = 1'b1;
                err_seg_d = smp_q[6:0];
            end
            // Counter parks at the limit; stale stays set until the next capture.
            if (tmo_q != TMO_MAX) begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_q + 1'b1 == TMO_MAX) begin
                    stale_d = 1'b1;
                    valid_d = 2'b00;
                    flag_d  = 2'b00;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            smp_q     <= IDLE_SMP;
            cnt_q     <= '0;
            digit0_q  <= '0;
            digit1_q  <= '0;
            valid_q   <= '0;
            flag_q    <= '0;
            frame_q   <= 1'b0;
            err_q     <= 1'b0;
            err_seg_q <= '0;
            stale_q   <= 1'b0;
            tmo_q     <= '0;
        end else begin
            smp_q     <= smp_d;
            cnt_q     <= cnt_d;
            digit0_q  <= digit0_d;
            digit1_q  <= digit1_d;
            valid_q   <= valid_d;
            flag_q    <= flag_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
            err_seg_q <= err_seg_d;
            stale_q   <= stale_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.digit0      = digit0_q;
    assign bus.digit1      = digit1_q;
    assign bus.valid       = valid_q;
    assign bus.frame_pulse = frame_q;
    assign bus.err_pulse   = err_q;
    assign bus.err_seg     = err_seg_q;
    assign bus.stale       = stale_q;
endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scenarios then random bus traffic, every cycle
// compared against a run-length/table reference model of the display monitor.
module tb_seven_seg_capture;
    localparam int STABLE = 4;
    localparam int TO     = 16;

    logic clk = 1'b0;
    logic reset;

    seven_seg_capture_if bus ();

    seven_seg_capture #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [1:0] a_cur;
    logic [6:0] s_cur;

    logic [6:0] segtab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h72, 7'h42, 7'h10, 7'h38};

    // Reference state: run length of the current input, cycles since last capture.
    logic [8:0] m_prev;
    int         m_run;
    int         m_idle;
    logic [3:0] m_dig [2];
    logic [1:0] m_valid;
    logic [1:0] m_flags;
    logic       m_frame;
    logic       m_err;
    logic [6:0] m_err_seg;
    logic       m_stale;

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (segtab[i] == s) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [1:0] a, input logic [6:0] s);
        int  di;
        int  v;
        bit  cap;
        if (r) begin
            m_prev = {2'b11, 7'h7F};
            m_run = 0; m_idle = 0;
            m_dig[0] = 4'h0; m_dig[1] = 4'h0;
            m_valid = 2'b00; m_flags = 2'b00;
            m_frame = 1'b0; m_err = 1'b0; m_err_seg = 7'h00; m_stale = 1'b0;
        end else begin
            m_run  = ({a, s} == m_prev) ? m_run + 1 : 0;
            m_prev = {a, s};
            m_frame = 1'b0;
            m_err   = 1'b0;
            cap     = 1'b0;
            if (m_run == STABLE) begin
                di = (a == 2'b10) ? 0 : (a == 2'b01) ? 1 : -1;
                if (di >= 0 && s != 7'h7F) begin
                    v = lookup(s);
                    if (v >= 0) begin
                        m_dig[di]   = 4'(v);
                        m_valid[di] = 1'b1;
                        m_flags[di] = 1'b1;
                        cap = 1'b1;
                        if (m_flags == 2'b11) begin
                            m_frame = 1'b1;
                            m_flags = 2'b00;
                        end
                    end else begin
                        m_err     = 1'b1;
                        m_err_seg = s;
                    end
                end
            end
            if (cap) begin
                m_idle  = 0;
                m_stale = 1'b0;
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_stale = 1'b1;
                    m_valid = 2'b00;
                    m_flags = 2'b00;
                end
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step(reset, a_cur, s_cur);
        #1;
        chk({tag, "/digit0"}, 32'(bus.digit0), 32'(m_dig[0]));
        chk({tag, "/digit1"}, 32'(bus.digit1), 32'(m_dig[1]));
        chk({tag, "/valid"},  32'(bus.valid),  32'(m_valid));
        chk({tag, "/frame"},  32'(bus.frame_pulse), 32'(m_frame));
        chk({tag, "/err"},    32'(bus.err_pulse),   32'(m_err));
        chk({tag, "/errseg"}, 32'(bus.err_seg), 32'(m_err_seg));
        chk({tag, "/stale"},  32'(bus.stale),   32'(m_stale));
    endtask

    task automatic drive(input logic [1:0] a, input logic [6:0] s, input int n, input string tag);
        a_cur  = a;
        s_cur  = s;
        bus.an = a;
        bus.seg = s;
        repeat (n) cycle(tag);
    endtask

    initial begin
        reset = 1'b1;
        // 1: reset with random inputs, then idle bus
        for (int i = 0; i < 3; i++) drive(2'($urandom), 7'($urandom), 1, "t1_rst");
        chk("t1_valid0", 32'(bus.valid), 32'h0);
        reset = 1'b0;
        drive(2'b11, 7'h7F, 10, "t1_idle");
        chk("t1_nothing", 32'({bus.valid, bus.frame_pulse, bus.err_pulse, bus.stale}), 32'h0);

        // 2: capture exactly at edge 4, no re-capture
        drive(2'b10, 7'h12, 4, "t2");
        chk("t2_edge3_valid", 32'(bus.valid), 32'h0);
        drive(2'b10, 7'h12, 1, "t2");
        chk("t2_digit0", 32'(bus.digit0), 32'h2);
        chk("t2_valid",  32'(bus.valid),  32'h1);
        drive(2'b10, 7'h12, 5, "t2_hold");

        // 3: short glitch is not captured
        drive(2'b10, 7'h12, 2, "t3");
        drive(2'b10, 7'h06, 4, "t3");
        chk("t3_pre", 32'(bus.digit0), 32'h2);
        drive(2'b10, 7'h06, 1, "t3");
        chk("t3_digit0", 32'(bus.digit0), 32'h3);

        // 4: both digits captured -> frame pulse
        drive(2'b10, 7'h4C, 5, "t4");
        drive(2'b01, 7'h38, 4, "t4");
        chk("t4_noframe", 32'(bus.frame_pulse), 32'h0);
        drive(2'b01, 7'h38, 1, "t4");
        chk("t4_frame",  32'(bus.frame_pulse), 32'h1);
        chk("t4_digit0", 32'(bus.digit0), 32'h4);
        chk("t4_digit1", 32'(bus.digit1), 32'hF);
        drive(2'b01, 7'h38, 1, "t4");
        chk("t4_frame_end", 32'(bus.frame_pulse), 32'h0);

        // 5: invalid pattern -> error, then blank -> nothing
        drive(2'b01, 7'h55, 5, "t5");
        chk("t5_err",    32'(bus.err_pulse), 32'h1);
        chk("t5_errseg", 32'(bus.err_seg), 32'h55);
        chk("t5_digit1", 32'(bus.digit1), 32'hF);
        chk("t5_valid",  32'(bus.valid), 32'h3);
        drive(2'b01, 7'h55, 1, "t5");
        drive(2'b01, 7'h7F, 6, "t5_blank");
        chk("t5_blank_err", 32'(bus.err_pulse), 32'h0);

        // 6: timeout to stale, recovery, and reset during a stable run
        drive(2'b10, 7'h01, 5, "t6");
        drive(2'b11, 7'h7F, 15, "t6_idle");
        chk("t6_notstale", 32'(bus.stale), 32'h0);
        drive(2'b11, 7'h7F, 1, "t6_idle");
        chk("t6_stale", 32'(bus.stale), 32'h1);
        chk("t6_valid", 32'(bus.valid), 32'h0);
        chk("t6_keep",  32'(bus.digit0), 32'h0);
        drive(2'b10, 7'h06, 5, "t6_rec");
        chk("t6_recover", 32'(bus.stale), 32'h0);
        chk("t6_digit0",  32'(bus.digit0), 32'h3);
        drive(2'b01, 7'h4F, 4, "t6_pre");
        reset = 1'b1;
        drive(2'b01, 7'h4F, 1, "t6_rst");
        chk("t6_rst_digit1", 32'(bus.digit1), 32'h0);
        chk("t6_rst_frame",  32'(bus.frame_pulse), 32'h0);
        reset = 1'b0;
        drive(2'b11, 7'h7F, 3, "t6_post");

        // random traffic
        for (int k = 0; k < 150; k++) begin
            logic [1:0] a;
            logic [6:0] s;
            int p;
            p = $urandom_range(0, 9);
            a = (p < 4) ? 2'b10 : (p < 8) ? 2'b01 : 2'($urandom);
            p = $urandom_range(0, 9);
            s = (p < 6) ? segtab[$urandom_range(0, 15)] : (p < 8) ? 7'h7F : 7'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                drive(a, s, 1, "rand_rst");
                reset = 1'b0;
            end
            drive(a, s, $urandom_range(1, 7), "rand");
        end
        drive(2'b11, 7'h7F, 20, "tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
